axi4_lite_master_bridge: RTL and testbench
==========================================

AXI4_LITE_MASTER_BRIDGE -- requirements
Module: axi4_lite_master_bridge

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, address width of all address ports.
REQ-002 Parameter: DATA_WIDTH, 32, data width; strobe width = DATA_WIDTH/8.
REQ-003 Parameter: TIMEOUT_CYCLES, 255, per-transaction cycle limit; used only with AXI_TIMEOUT_EN.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Ports from the memory stage: write_start in 1, write_addr in ADDR_WIDTH, write_data in DATA_WIDTH, write_strobe in DATA_WIDTH/8, read_start in 1, read_addr in ADDR_WIDTH.
REQ-007 Ports to the memory stage: write_busy out 1, read_busy out 1, read_data out DATA_WIDTH, resp_err out 1 (one-cycle error pulse).
REQ-008 AXI write ports: m_awaddr out, m_awvalid out, m_awready in, m_wdata out, m_wstrb out, m_wvalid out, m_wready in, m_bresp in 2, m_bvalid in, m_bready out.
REQ-009 AXI read ports: m_araddr out, m_arvalid out, m_arready in, m_rdata in, m_rresp in 2, m_rvalid in, m_rready out.

Function
REQ-010 Write FSM states: W_IDLE, W_REQ, W_RESP. Read FSM states: R_IDLE, R_REQ, R_DATA. The two FSMs are fully independent.
REQ-011 W_IDLE with write_start=1: latch addr/data/strobe; enter W_REQ next cycle with m_awvalid=m_wvalid=1.
REQ-012 In W_REQ, AW and W complete independently: each valid drops the cycle after its own valid&ready. Once both have completed, including in the same cycle, the FSM enters W_RESP.
REQ-013 In W_RESP, m_bready=1. On m_bvalid, return to W_IDLE; m_bresp!=0 pulses resp_err for 1 cycle.
REQ-014 write_busy = write_start | (write FSM != W_IDLE), combinational. This allows the stall to take effect in the start cycle.
REQ-015 R_IDLE with read_start=1: latch addr; enter R_REQ with m_arvalid=1. On arvalid&arready, enter R_DATA with m_rready=1.
REQ-016 In R_DATA, on m_rvalid, capture m_rdata into read_data and return to R_IDLE. read_data holds until the next capture. m_rresp!=0 pulses resp_err; the data is still captured.
REQ-017 read_busy = read_start | (read FSM != R_IDLE), combinational.
REQ-018 write_start while the write FSM is not idle is ignored; the same applies to read_start and the read FSM.
REQ-019 Simultaneous write_start and read_start launch both channels in the same cycle.
REQ-020 A write error and a read error in the same cycle produce a single resp_err pulse.
REQ-021 m_awaddr/m_wdata/m_wstrb/m_araddr come from the latched registers and stay stable while their valid is high.
REQ-022 No combinational path from any AXI input to any AXI valid/ready output.

Reset
REQ-023 rst=0 asynchronously forces both FSMs idle and all valids, readys and resp_err to 0.
REQ-024 On reset, read_data and all latched address, data and strobe registers clear to 0.
REQ-025 Reset asserted mid-transaction abandons the transaction with no resp_err; operation resumes idle after rst=1.

Configuration
REQ-026 Macro AXI_TIMEOUT_EN defined: each FSM has a cycle counter, cleared on leaving idle.
REQ-027 With AXI_TIMEOUT_EN, if the counter reaches TIMEOUT_CYCLES before completion, the FSM forces idle, drops its valid/ready, and pulses resp_err. A read timeout also loads read_data=32'hDEADBEEF.
REQ-028 Macro AXI_TIMEOUT_EN undefined: no counters exist, transactions wait indefinitely, and TIMEOUT_CYCLES has no effect.

Verification
REQ-029 Write 0x40000000/0x000000A5/strb 0xF, with awready and wready at 1 and bvalid one cycle later with bresp=0 -> AW and W handshake in the first REQ cycle; write_busy high 3 cycles; resp_err stays 0.
REQ-030 Write with awready delayed 4 cycles and wready immediate -> wvalid drops after 1 cycle; awvalid is held 4 cycles with a stable address; W_RESP is entered only after AW completes.
REQ-031 Read 0x40000004 with rdata=0x12345678 and rresp=2 -> read_data=0x12345678; resp_err pulses for exactly 1 cycle; read_busy drops afterwards.
REQ-032 write_start and read_start in the same cycle, with a second write_start while busy -> awvalid and arvalid rise together; the second start produces no AW.
REQ-033 rst pulled low in W_RESP while bvalid is withheld -> m_bready=0 immediately; after release, a new write completes normally.
REQ-034 With AXI_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read whose arready is never asserted -> arvalid drops at cycle 8; read_data=0xDEADBEEF; resp_err pulses.

Source files
------------

// File: rtl/axi4_lite_master_bridge.sv
// AXI4-Lite master bridge: independent write and read channel FSMs between the memory stage and AXI.
// Optional per-transaction timeout enabled by defining the macro AXI_TIMEOUT_EN.
module axi4_lite_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write_start,
   input  logic [ADDR_WIDTH-1:0]   write_addr,
   input  logic [DATA_WIDTH-1:0]   write_data,
   input  logic [DATA_WIDTH/8-1:0] write_strobe,
   input  logic                    read_start,
   input  logic [ADDR_WIDTH-1:0]   read_addr,
   output logic                    write_busy,
   output logic                    read_busy,
   output logic [DATA_WIDTH-1:0]   read_data,
   output logic                    resp_err,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_REQ  = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_REQ  = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   logic [1:0]            w_state_q, w_state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  w_err_s;

   logic [1:0]            r_state_q, r_state_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
   logic                  r_err_s;

   logic                  resp_err_q, resp_err_d;

`ifdef AXI_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
   logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
`else
   logic [31:0] unused_timeout_s;
   assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

   // Write channel next-state: AW and W retire independently, then wait for B.
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      w_err_s   = 1'b0;
`ifdef AXI_TIMEOUT_EN
      w_cnt_d   = w_cnt_q;
`endif
      case (w_state_q)
         W_IDLE: begin
            if (write_start) begin
               awaddr_d  = write_addr;
               wdata_d   = write_data;
               wstrb_d   = write_strobe;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               w_state_d = W_REQ;
            end else begin
               awvalid_d = 1'b0;
               wvalid_d  = 1'b0;
            end
         end
         W_REQ: begin
            awvalid_d = awvalid_q & ~m_awready;
            wvalid_d  = wvalid_q & ~m_wready;
            if (!awvalid_d && !wvalid_d) begin
               bready_d  = 1'b1;
               w_state_d = W_RESP;
            end else begin
               bready_d  = 1'b0;
            end
         end
         W_RESP: begin
            if (m_bvalid) begin
               bready_d  = 1'b0;
               w_err_s   = (m_bresp != 2'b00);
               w_state_d = W_IDLE;
            end else begin
               bready_d  = 1'b1;
            end
         end
         default: begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            w_state_d = W_IDLE;
         end
      endcase
`ifdef AXI_TIMEOUT_EN
      // A completing handshake wins over an expiring counter.
      if (w_state_q != W_IDLE) begin
         w_cnt_d = w_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if ((w_state_d != W_IDLE) && (w_cnt_q == CNT_LIMIT)) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            w_err_s   = 1'b1;
            w_state_d = W_IDLE;
         end else begin
            w_err_s   = w_err_s;
         end
      end else begin
         w_cnt_d = {CNT_W{1'b0}};
      end
`endif
   end

   // Read channel next-state: AR handshake, then capture one R beat.
   always_comb begin
      r_state_d   = r_state_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      read_data_d = read_data_q;
      r_err_s     = 1'b0;
`ifdef AXI_TIMEOUT_EN
      r_cnt_d     = r_cnt_q;
`endif
      case (r_state_q)
         R_IDLE: begin
            if (read_start) begin
               araddr_d  = read_addr;
               arvalid_d = 1'b1;
               r_state_d = R_REQ;
            end else begin
               arvalid_d = 1'b0;
            end
         end
         R_REQ: begin
            if (m_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               r_state_d = R_DATA;
            end else begin
               arvalid_d = 1'b1;
            end
         end
         R_DATA: begin
            if (m_rvalid) begin
               read_data_d = m_rdata;
               rready_d    = 1'b0;
               r_err_s     = (m_rresp != 2'b00);
               r_state_d   = R_IDLE;
            end else begin
               rready_d    = 1'b1;
            end
         end
         default: begin
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            r_state_d = R_IDLE;
         end
      endcase
`ifdef AXI_TIMEOUT_EN
      if (r_state_q != R_IDLE) begin
         r_cnt_d = r_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         if ((r_state_d != R_IDLE) && (r_cnt_q == CNT_LIMIT)) begin
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            r_err_s     = 1'b1;
            read_data_d = DATA_WIDTH'(32'hDEADBEEF);
            r_state_d   = R_IDLE;
         end else begin
            r_err_s     = r_err_s;
         end
      end else begin
         r_cnt_d = {CNT_W{1'b0}};
      end
`endif
   end

   // Simultaneous write and read errors merge into one pulse.
   always_comb begin
      resp_err_d = w_err_s | r_err_s;
   end

   // State and output registers; reset abandons any transaction silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_state_q   <= W_IDLE;
         awaddr_q    <= {ADDR_WIDTH{1'b0}};
         wdata_q     <= {DATA_WIDTH{1'b0}};
         wstrb_q     <= {STRB_WIDTH{1'b0}};
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         r_state_q   <= R_IDLE;
         araddr_q    <= {ADDR_WIDTH{1'b0}};
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         read_data_q <= {DATA_WIDTH{1'b0}};
         resp_err_q  <= 1'b0;
`ifdef AXI_TIMEOUT_EN
         w_cnt_q     <= {CNT_W{1'b0}};
         r_cnt_q     <= {CNT_W{1'b0}};
`endif
      end else begin
         w_state_q   <= w_state_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         r_state_q   <= r_state_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         read_data_q <= read_data_d;
         resp_err_q  <= resp_err_d;
`ifdef AXI_TIMEOUT_EN
         w_cnt_q     <= w_cnt_d;
         r_cnt_q     <= r_cnt_d;
`endif
      end
   end

   assign write_busy = write_start | (w_state_q != W_IDLE);
   assign read_busy  = read_start | (r_state_q != R_IDLE);
   assign read_data  = read_data_q;
   assign resp_err   = resp_err_q;
   assign m_awaddr   = awaddr_q;
   assign m_awvalid  = awvalid_q;
   assign m_wdata    = wdata_q;
   assign m_wstrb    = wstrb_q;
   assign m_wvalid   = wvalid_q;
   assign m_bready   = bready_q;
   assign m_araddr   = araddr_q;
   assign m_arvalid  = arvalid_q;
   assign m_rready   = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge; checks sampled on the falling clock edge.
module tb_axi4_lite_master_bridge;

   logic        clk;
   logic        rst;
   logic        write_start;
   logic [31:0] write_addr;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        read_start;
   logic [31:0] read_addr;
   logic        write_busy;
   logic        read_busy;
   logic [31:0] read_data;
   logic        resp_err;
   logic [31:0] m_awaddr;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_wvalid;
   logic        m_wready;
   logic [1:0]  m_bresp;
   logic        m_bvalid;
   logic        m_bready;
   logic [31:0] m_araddr;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid;
   logic        m_rready;

   int tests_run;
   int tests_failed;
   int hi_cnt;

   axi4_lite_master_bridge #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .write_start (write_start),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_strobe(write_strobe),
      .read_start  (read_start),
      .read_addr   (read_addr),
      .write_busy  (write_busy),
      .read_busy   (read_busy),
      .read_data   (read_data),
      .resp_err    (resp_err),
      .m_awaddr    (m_awaddr),
      .m_awvalid   (m_awvalid),
      .m_awready   (m_awready),
      .m_wdata     (m_wdata),
      .m_wstrb     (m_wstrb),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .m_bresp     (m_bresp),
      .m_bvalid    (m_bvalid),
      .m_bready    (m_bready),
      .m_araddr    (m_araddr),
      .m_arvalid   (m_arvalid),
      .m_arready   (m_arready),
      .m_rdata     (m_rdata),
      .m_rresp     (m_rresp),
      .m_rvalid    (m_rvalid),
      .m_rready    (m_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b0;
      write_start  = 1'b0;
      write_addr   = 32'h0;
      write_data   = 32'h0;
      write_strobe = 4'h0;
      read_start   = 1'b0;
      read_addr    = 32'h0;
      m_awready    = 1'b0;
      m_wready     = 1'b0;
      m_bresp      = 2'b00;
      m_bvalid     = 1'b0;
      m_arready    = 1'b0;
      m_rdata      = 32'h0;
      m_rresp      = 2'b00;
      m_rvalid     = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_awvalid", m_awvalid, 1'b0);
      chk("rst_wvalid", m_wvalid, 1'b0);
      chk("rst_bready", m_bready, 1'b0);
      chk("rst_arvalid", m_arvalid, 1'b0);
      chk("rst_rready", m_rready, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_wbusy", write_busy, 1'b0);
      rst = 1'b1;
      tick();

      // simple write, both handshakes in the first request cycle
      write_start = 1'b1; write_addr = 32'h4000_0000; write_data = 32'h0000_00A5;
      write_strobe = 4'hF; m_awready = 1'b1; m_wready = 1'b1;
      #1 chk("w1_busy_start", write_busy, 1'b1);
      tick();
      write_start = 1'b0;
      chk("w1_awvalid", m_awvalid, 1'b1);
      chk("w1_wvalid", m_wvalid, 1'b1);
      chk("w1_awaddr", m_awaddr, 32'h4000_0000);
      chk("w1_wdata", m_wdata, 32'h0000_00A5);
      chk("w1_wstrb", m_wstrb, 4'hF);
      chk("w1_busy_req", write_busy, 1'b1);
      tick();
      m_awready = 1'b0; m_wready = 1'b0;
      chk("w1_aw_done", m_awvalid, 1'b0);
      chk("w1_w_done", m_wvalid, 1'b0);
      chk("w1_bready", m_bready, 1'b1);
      chk("w1_busy_resp", write_busy, 1'b1);
      m_bvalid = 1'b1; m_bresp = 2'b00;
      tick();
      m_bvalid = 1'b0;
      chk("w1_bready_low", m_bready, 1'b0);
      chk("w1_busy_end", write_busy, 1'b0);
      chk("w1_err0", resp_err, 1'b0);
      tick();
      chk("w1_err1", resp_err, 1'b0);

      // AW delayed 4 cycles, W immediate; ends with SLVERR
      write_start = 1'b1; write_addr = 32'h4000_0010; write_data = 32'h1122_3344;
      write_strobe = 4'h3; m_wready = 1'b1;
      tick();
      write_start = 1'b0;
      chk("w2_awvalid_c1", m_awvalid, 1'b1);
      chk("w2_wvalid_c1", m_wvalid, 1'b1);
      tick();
      m_wready = 1'b0;
      chk("w2_wvalid_drop", m_wvalid, 1'b0);
      chk("w2_awvalid_c2", m_awvalid, 1'b1);
      chk("w2_bready_c2", m_bready, 1'b0);
      tick();
      chk("w2_awvalid_c3", m_awvalid, 1'b1);
      chk("w2_awaddr_c3", m_awaddr, 32'h4000_0010);
      chk("w2_bready_c3", m_bready, 1'b0);
      tick();
      m_awready = 1'b1;
      chk("w2_awvalid_c4", m_awvalid, 1'b1);
      chk("w2_awaddr_c4", m_awaddr, 32'h4000_0010);
      chk("w2_bready_c4", m_bready, 1'b0);
      tick();
      m_awready = 1'b0;
      chk("w2_aw_done", m_awvalid, 1'b0);
      chk("w2_bready", m_bready, 1'b1);
      m_bvalid = 1'b1; m_bresp = 2'b10;
      tick();
      m_bvalid = 1'b0; m_bresp = 2'b00;
      chk("w2_err_pulse", resp_err, 1'b1);
      chk("w2_busy_end", write_busy, 1'b0);
      tick();
      chk("w2_err_clear", resp_err, 1'b0);

      // read with SLVERR response, data still captured
      read_start = 1'b1; read_addr = 32'h4000_0004; m_arready = 1'b1;
      #1 chk("r1_busy_start", read_busy, 1'b1);
      tick();
      read_start = 1'b0;
      chk("r1_arvalid", m_arvalid, 1'b1);
      chk("r1_araddr", m_araddr, 32'h4000_0004);
      tick();
      m_arready = 1'b0;
      chk("r1_ar_done", m_arvalid, 1'b0);
      chk("r1_rready", m_rready, 1'b1);
      m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'b10;
      tick();
      m_rvalid = 1'b0; m_rdata = 32'hFFFF_FFFF; m_rresp = 2'b00;
      chk("r1_read_data", read_data, 32'h1234_5678);
      chk("r1_err_pulse", resp_err, 1'b1);
      chk("r1_busy_end", read_busy, 1'b0);
      chk("r1_rready_low", m_rready, 1'b0);
      tick();
      chk("r1_err_clear", resp_err, 1'b0);
      chk("r1_data_hold", read_data, 32'h1234_5678);

      // simultaneous starts, ignored second write start, merged errors
      write_start = 1'b1; write_addr = 32'h4000_0020; write_data = 32'hCAFE_F00D;
      write_strobe = 4'hF; read_start = 1'b1; read_addr = 32'h4000_0030;
      tick();
      read_start = 1'b0;
      write_addr = 32'h5000_0000; write_data = 32'h0;
      chk("c_awvalid", m_awvalid, 1'b1);
      chk("c_arvalid", m_arvalid, 1'b1);
      chk("c_araddr", m_araddr, 32'h4000_0030);
      tick();
      write_start = 1'b0;
      chk("c_awaddr_kept", m_awaddr, 32'h4000_0020);
      chk("c_wdata_kept", m_wdata, 32'hCAFE_F00D);
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
      tick();
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
      chk("c_bready", m_bready, 1'b1);
      chk("c_rready", m_rready, 1'b1);
      m_bvalid = 1'b1; m_bresp = 2'b10;
      m_rvalid = 1'b1; m_rresp = 2'b11; m_rdata = 32'h0BAD_F00D;
      tick();
      m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00;
      chk("c_err_pulse", resp_err, 1'b1);
      chk("c_read_data", read_data, 32'h0BAD_F00D);
      tick();
      chk("c_err_single", resp_err, 1'b0);
      chk("c_no_second_aw", m_awvalid, 1'b0);
      chk("c_wbusy_idle", write_busy, 1'b0);

      // reset asserted in W_RESP with bvalid withheld
      write_start = 1'b1; write_addr = 32'h4000_0040; write_data = 32'h0000_0077;
      write_strobe = 4'h1; m_awready = 1'b1; m_wready = 1'b1;
      tick();
      write_start = 1'b0;
      tick();
      m_awready = 1'b0; m_wready = 1'b0;
      chk("rr_bready_before", m_bready, 1'b1);
      #2 rst = 1'b0;
      #1 chk("rr_bready_async", m_bready, 1'b0);
      chk("rr_awaddr_clr", m_awaddr, 32'h0);
      chk("rr_wbusy", write_busy, 1'b0);
      chk("rr_err", resp_err, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      chk("rr_err_after", resp_err, 1'b0);
      write_start = 1'b1; write_addr = 32'h4000_0050; write_data = 32'h0000_0099;
      write_strobe = 4'hF; m_awready = 1'b1; m_wready = 1'b1;
      tick();
      write_start = 1'b0;
      chk("rr2_awaddr", m_awaddr, 32'h4000_0050);
      tick();
      m_awready = 1'b0; m_wready = 1'b0;
      chk("rr2_bready", m_bready, 1'b1);
      m_bvalid = 1'b1;
      tick();
      m_bvalid = 1'b0;
      chk("rr2_busy_end", write_busy, 1'b0);
      chk("rr2_err", resp_err, 1'b0);

      // read whose arready never arrives
      read_start = 1'b1; read_addr = 32'h4000_0060;
      tick();
      read_start = 1'b0;
      hi_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (m_arvalid === 1'b1) hi_cnt++;
         tick();
      end
`ifdef AXI_TIMEOUT_EN
      chk("to_arvalid_cycles", hi_cnt, 8);
      chk("to_arvalid_low", m_arvalid, 1'b0);
      chk("to_read_data", read_data, 32'hDEAD_BEEF);
      chk("to_rbusy", read_busy, 1'b0);
`else
      chk("nto_arvalid_cycles", hi_cnt, 20);
      chk("nto_arvalid_held", m_arvalid, 1'b1);
      chk("nto_rbusy", read_busy, 1'b1);
      chk("nto_err", resp_err, 1'b0);
      m_arready = 1'b1;
      tick();
      m_arready = 1'b0;
      m_rvalid = 1'b1; m_rdata = 32'hA5A5_0001;
      tick();
      m_rvalid = 1'b0;
      chk("nto_read_data", read_data, 32'hA5A5_0001);
      chk("nto_rbusy_end", read_busy, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

`ifdef AXI_TIMEOUT_EN
   // resp_err must pulse exactly on the timeout cycle
   int to_err_seen = 0;
   always @(negedge clk) begin
      if (rst && resp_err && (read_data == 32'hDEAD_BEEF)) to_err_seen <= to_err_seen + 1;
   end
   final begin
      if (to_err_seen != 1) $display("FAIL to_err_pulse: observed %0d expected 1", to_err_seen);
   end
`endif

endmodule
